// File: rtl/stepdir_generator_pkg.sv
// Shared state encoding, default widths and position helper for the
// step/direction pulse generator.
package stepdir_generator_pkg;

  localparam int DEF_COUNT_WIDTH    = 16;
  localparam int DEF_INTERVAL_WIDTH = 16;
  localparam int CFG_WIDTH          = 8;
  localparam int POS_WIDTH          = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIR_SETUP,
    S_STEP_HIGH,
    S_STEP_LOW,
    S_DONE
  } state_e;

  function automatic logic [POS_WIDTH-1:0] next_pos(input logic [POS_WIDTH-1:0] pos,
                                                    input logic fwd);
    return fwd ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/stepdir_generator_mytimer.sv
// Phase timer: loads on start_enable_i, counts down and rests at zero.
module mytimer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_enable_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                count_q <= '0;
    else if (start_enable_i)    count_q <= load_value_i;
    else if (count_q != '0)     count_q <= count_q - WIDTH'(1);
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/stepdir_generator.sv
// Step/direction pulse generator with one active and one pending move.
// state       | meaning
// IDLE        | no active move
// LOAD        | pending move copied to active, slot freed
// DIR_SETUP   | dir changed, waiting before first step edge
// STEP_HIGH   | step pulse high for PW cycles
// STEP_LOW    | step low for remainder of the step period
// DONE        | one-cycle done pulse
module stepdir_generator
  import stepdir_generator_pkg::*;
#(
  parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
  parameter int INTERVAL_WIDTH = DEF_INTERVAL_WIDTH
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        move_valid,
  output logic                        move_ready,
  input  logic                        move_dir,
  input  logic [COUNT_WIDTH-1:0]      move_steps,
  input  logic [INTERVAL_WIDTH-1:0]   move_interval,
  input  logic [CFG_WIDTH-1:0]        config_pulse_width,
  input  logic [CFG_WIDTH-1:0]        config_dir_setup,
  input  logic                        abort,
  output logic                        step,
  output logic                        dir,
  output logic                        busy,
  output logic                        done,
  output logic signed [POS_WIDTH-1:0] position
);

  localparam int TW = ((INTERVAL_WIDTH > CFG_WIDTH) ? INTERVAL_WIDTH : CFG_WIDTH) + 1;

  state_e                    state_q, state_d;
  logic                      pend_full_q, pend_dir_q;
  logic [COUNT_WIDTH-1:0]    pend_steps_q;
  logic [INTERVAL_WIDTH-1:0] pend_interval_q;
  logic [COUNT_WIDTH-1:0]    steps_q, steps_d;
  logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
  logic [CFG_WIDTH-1:0]      pw_q, pw_d;
  logic                      dir_q, dir_d, abort_q, abort_d;
  logic [POS_WIDTH-1:0]      pos_q, pos_d;
  logic                      accept, tmr_start, tmr_expired;
  logic [TW-1:0]             tmr_load, period, low_load;
  logic [CFG_WIDTH-1:0]      pw_cfg_eff, ds_cfg_eff;

  assign accept     = move_valid && move_ready;
  assign pw_cfg_eff = (config_pulse_width == '0) ? CFG_WIDTH'(1) : config_pulse_width;
  assign ds_cfg_eff = (config_dir_setup == '0) ? CFG_WIDTH'(1) : config_dir_setup;
  // Step period is at least PW+1 so every pulse has a low phase.
  assign period     = (TW'(interval_q) > TW'(pw_q) + TW'(1)) ? TW'(interval_q)
                                                              : TW'(pw_q) + TW'(1);
  assign low_load   = period - TW'(pw_q) - TW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_full_q     <= 1'b0;
      pend_dir_q      <= 1'b0;
      pend_steps_q    <= '0;
      pend_interval_q <= '0;
    end else if (abort) begin
      pend_full_q <= 1'b0;
    end else if (accept) begin
      pend_full_q     <= 1'b1;
      pend_dir_q      <= move_dir;
      pend_steps_q    <= move_steps;
      pend_interval_q <= move_interval;
    end else if (state_q == S_LOAD) begin
      pend_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      steps_q    <= '0;
      interval_q <= '0;
      pw_q       <= CFG_WIDTH'(1);
      dir_q      <= 1'b0;
      abort_q    <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      steps_q    <= steps_d;
      interval_q <= interval_d;
      pw_q       <= pw_d;
      dir_q      <= dir_d;
      abort_q    <= abort_d;
      pos_q      <= pos_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    interval_d = interval_q;
    pw_d       = pw_q;
    dir_d      = dir_q;
    abort_d    = abort_q;
    pos_d      = pos_q;
    tmr_start  = 1'b0;
    tmr_load   = '0;
    unique case (state_q)
      S_IDLE: if (pend_full_q && !abort) state_d = S_LOAD;
      S_LOAD: begin
        steps_d    = pend_steps_q;
        interval_d = pend_interval_q;
        pw_d       = pw_cfg_eff;
        if (abort) begin
          state_d = S_IDLE;
        end else if (pend_steps_q == '0) begin
          state_d = S_DONE;
        end else if (pend_dir_q != dir_q) begin
          dir_d     = pend_dir_q;
          state_d   = S_DIR_SETUP;
          tmr_start = 1'b1;
          tmr_load  = TW'(ds_cfg_eff) - TW'(1);
        end else begin
          state_d   = S_STEP_HIGH;
          tmr_start = 1'b1;
          tmr_load  = TW'(pw_cfg_eff) - TW'(1);
          pos_d     = next_pos(pos_q, dir_q);
        end
      end
      S_DIR_SETUP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_expired) begin
          state_d   = S_STEP_HIGH;
          tmr_start = 1'b1;
          tmr_load  = TW'(pw_q) - TW'(1);
          pos_d     = next_pos(pos_q, dir_q);
        end
      end
      S_STEP_HIGH: begin
        // An abort here is remembered so the pulse still completes its width.
        abort_d = abort_q || abort;
        if (tmr_expired) begin
          if (abort_q || abort) begin
            state_d = S_IDLE;
            abort_d = 1'b0;
          end else begin
            state_d   = S_STEP_LOW;
            tmr_start = 1'b1;
            tmr_load  = low_load;
          end
        end
      end
      S_STEP_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_expired) begin
          steps_d = steps_q - COUNT_WIDTH'(1);
          if (steps_q == COUNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_STEP_HIGH;
            tmr_start = 1'b1;
            tmr_load  = TW'(pw_q) - TW'(1);
            pos_d     = next_pos(pos_q, dir_q);
          end
        end
      end
      S_DONE:  state_d = (pend_full_q && !abort) ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  mytimer #(.WIDTH(TW)) u_timer (
    .clk            (clk),
    .resetn         (resetn),
    .start_enable_i (tmr_start),
    .load_value_i   (tmr_load),
    .expired_o      (tmr_expired)
  );

  assign move_ready = !pend_full_q;
  assign step       = (state_q == S_STEP_HIGH);
  assign done       = (state_q == S_DONE);
  assign dir        = dir_q;
  assign busy       = !((state_q == S_IDLE) && !pend_full_q);
  assign position   = pos_q;

endmodule
